// File: rtl/tri_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tri_pkg
//  Purpose  : Shared widths, point type, FSM state and sub-job encodings for
//             the point-in-triangle raster scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package tri_pkg;

    localparam int X_W   = 11;
    localparam int Y_W   = 10;
    localparam int DET_W = 22;
    localparam int SUM_W = DET_W + 2;   // three DET_W terms cannot overflow

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } pt_t;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_BBOX      = 4'd1,
        ST_AREA_REQ  = 4'd2,
        ST_AREA_WAIT = 4'd3,
        ST_SUB_REQ   = 4'd4,
        ST_SUB_WAIT  = 4'd5,
        ST_EMIT      = 4'd6,
        ST_NEXT      = 4'd7,
        ST_DONE      = 4'd8
    } state_t;

    // Which sub-triangle is being measured against the current pixel P
    typedef enum logic [1:0] {
        SUB_ABP = 2'd0,
        SUB_ACP = 2'd1,
        SUB_BCP = 2'd2
    } sub_t;

endpackage
`default_nettype wire

// File: rtl/tri_bbox.sv
`default_nettype none
// ============================================================================
//  Module   : tri_bbox
//  Purpose  : Combinational unsigned min/max of three points (bounding box).
//  Revision : 1.0 - initial release
// ============================================================================
module tri_bbox
    import tri_pkg::*;
(
    input  pt_t i_a,
    input  pt_t i_b,
    input  pt_t i_c,
    output pt_t o_min,
    output pt_t o_max
);

    logic [X_W-1:0] w_xmin_ab;
    logic [X_W-1:0] w_xmax_ab;
    logic [Y_W-1:0] w_ymin_ab;
    logic [Y_W-1:0] w_ymax_ab;

    // Reduce A/B first, then fold in C, independently per axis
    always_comb begin
        w_xmin_ab = (i_a.x < i_b.x) ? i_a.x : i_b.x;
        w_xmax_ab = (i_a.x > i_b.x) ? i_a.x : i_b.x;
        w_ymin_ab = (i_a.y < i_b.y) ? i_a.y : i_b.y;
        w_ymax_ab = (i_a.y > i_b.y) ? i_a.y : i_b.y;
        o_min.x   = (w_xmin_ab < i_c.x) ? w_xmin_ab : i_c.x;
        o_max.x   = (w_xmax_ab > i_c.x) ? w_xmax_ab : i_c.x;
        o_min.y   = (w_ymin_ab < i_c.y) ? w_ymin_ab : i_c.y;
        o_max.y   = (w_ymax_ab > i_c.y) ? w_ymax_ab : i_c.y;
    end

endmodule
`default_nettype wire

// File: rtl/tri_raster_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tri_raster_sched
//  Purpose  : Walks the bounding box of one triangle row-major and, per pixel,
//             sequences a shared |det| unit through ABP/ACP/BCP, comparing the
//             sum with area(ABC) to classify the pixel inside/outside.
//  Options  : TRI_RASTER_EARLY_EXIT_EN - stop sub-determinants for a pixel as
//             soon as the running sum exceeds the triangle area.
//  Revision : 1.0 - initial release
// ============================================================================
module tri_raster_sched
    import tri_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tri_valid,
    output logic             tri_ready,
    input  logic [X_W-1:0]   tri_ax,
    input  logic [X_W-1:0]   tri_bx,
    input  logic [X_W-1:0]   tri_cx,
    input  logic [Y_W-1:0]   tri_ay,
    input  logic [Y_W-1:0]   tri_by,
    input  logic [Y_W-1:0]   tri_cy,
    output logic             det_req,
    input  logic             det_ack,
    output logic [X_W-1:0]   det_px,
    output logic [X_W-1:0]   det_qx,
    output logic [X_W-1:0]   det_rx,
    output logic [Y_W-1:0]   det_py,
    output logic [Y_W-1:0]   det_qy,
    output logic [Y_W-1:0]   det_ry,
    input  logic             det_rsp_valid,
    input  logic [DET_W-1:0] det_rsp_abs,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [X_W-1:0]   pix_x,
    output logic [Y_W-1:0]   pix_y,
    output logic             pix_inside,
    output logic             pix_last,
    output logic             tri_done
);

    state_t           r_state;
    state_t           w_state_nxt;
    pt_t              r_a;
    pt_t              r_b;
    pt_t              r_c;
    pt_t              r_pix;
    pt_t              r_max;
    logic [X_W-1:0]   r_xmin;
    logic [DET_W-1:0] r_area;
    logic [SUM_W-1:0] r_sum;
    sub_t             r_k;

    pt_t              w_min;
    pt_t              w_max;
    pt_t              w_p;
    pt_t              w_q;
    pt_t              w_r;
    logic             w_last;
    logic [SUM_W-1:0] w_rsp_ext;
    logic [SUM_W-1:0] w_area_ext;
    logic [SUM_W-1:0] w_sum_acc;

    tri_bbox u_bbox (
        .i_a   (r_a),
        .i_b   (r_b),
        .i_c   (r_c),
        .o_min (w_min),
        .o_max (w_max)
    );

    assign w_rsp_ext  = {{(SUM_W-DET_W){1'b0}}, det_rsp_abs};
    assign w_area_ext = {{(SUM_W-DET_W){1'b0}}, r_area};
    assign w_sum_acc  = r_sum + w_rsp_ext;
    assign w_last     = (r_pix.x == r_max.x) && (r_pix.y == r_max.y);

    assign det_px = w_p.x;
    assign det_py = w_p.y;
    assign det_qx = w_q.x;
    assign det_qy = w_q.y;
    assign det_rx = w_r.x;
    assign det_ry = w_r.y;
    assign pix_x  = r_pix.x;
    assign pix_y  = r_pix.y;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and Moore outputs; operands are zero unless requesting
    always_comb begin
        w_state_nxt = r_state;
        tri_ready   = 1'b0;
        tri_done    = 1'b0;
        det_req     = 1'b0;
        pix_valid   = 1'b0;
        pix_inside  = 1'b0;
        pix_last    = 1'b0;
        w_p         = '0;
        w_q         = '0;
        w_r         = '0;
        case (r_state)
            ST_IDLE: begin
                tri_ready = 1'b1;
                if (tri_valid) begin
                    w_state_nxt = ST_BBOX;
                end
            end
            ST_BBOX: begin
                w_state_nxt = ST_AREA_REQ;
            end
            ST_AREA_REQ: begin
                det_req = 1'b1;
                w_p     = r_a;
                w_q     = r_b;
                w_r     = r_c;
                if (det_ack) begin
                    w_state_nxt = ST_AREA_WAIT;
                end
            end
            ST_AREA_WAIT: begin
                if (det_rsp_valid) begin
                    // Zero area covers both coincident and collinear vertices
                    w_state_nxt = (det_rsp_abs == '0) ? ST_DONE : ST_SUB_REQ;
                end
            end
            ST_SUB_REQ: begin
                det_req = 1'b1;
                w_r     = r_pix;
                case (r_k)
                    SUB_ABP: begin w_p = r_a; w_q = r_b; end
                    SUB_ACP: begin w_p = r_a; w_q = r_c; end
                    default: begin w_p = r_b; w_q = r_c; end
                endcase
                if (det_ack) begin
                    w_state_nxt = ST_SUB_WAIT;
                end
            end
            ST_SUB_WAIT: begin
                if (det_rsp_valid) begin
                    if (r_k == SUB_BCP) begin
                        w_state_nxt = ST_EMIT;
`ifdef TRI_RASTER_EARLY_EXIT_EN
                    end else if (w_sum_acc > w_area_ext) begin
                        // Sum can only grow, so the pixel is already outside
                        w_state_nxt = ST_EMIT;
`endif
                    end else begin
                        w_state_nxt = ST_SUB_REQ;
                    end
                end
            end
            ST_EMIT: begin
                pix_valid  = 1'b1;
                pix_inside = (r_sum == w_area_ext);
                pix_last   = w_last;
                if (pix_ready) begin
                    w_state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                w_state_nxt = w_last ? ST_DONE : ST_SUB_REQ;
            end
            ST_DONE: begin
                tri_done    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Triangle, bounding box, pixel cursor and accumulator datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_c    <= '0;
            r_pix  <= '0;
            r_max  <= '0;
            r_xmin <= '0;
            r_area <= '0;
            r_sum  <= '0;
            r_k    <= SUB_ABP;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (tri_valid) begin
                        r_a.x <= tri_ax;
                        r_a.y <= tri_ay;
                        r_b.x <= tri_bx;
                        r_b.y <= tri_by;
                        r_c.x <= tri_cx;
                        r_c.y <= tri_cy;
                    end
                end
                ST_BBOX: begin
                    r_xmin <= w_min.x;
                    r_max  <= w_max;
                    r_pix  <= w_min;
                end
                ST_AREA_WAIT: begin
                    if (det_rsp_valid) begin
                        r_area <= det_rsp_abs;
                        r_sum  <= '0;
                        r_k    <= SUB_ABP;
                    end
                end
                ST_SUB_WAIT: begin
                    if (det_rsp_valid) begin
                        r_sum <= w_sum_acc;
                        r_k   <= (r_k == SUB_ABP) ? SUB_ACP : SUB_BCP;
                    end
                end
                ST_NEXT: begin
                    if (!w_last) begin
                        if (r_pix.x == r_max.x) begin
                            r_pix.x <= r_xmin;
                            r_pix.y <= r_pix.y + 1'b1;
                        end else begin
                            r_pix.x <= r_pix.x + 1'b1;
                        end
                    end
                    r_sum <= '0;
                    r_k   <= SUB_ABP;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tri_raster_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tri_raster_sched
//  Purpose  : Directed bench for tri_raster_sched with a behavioural shared
//             |det| unit whose ack/response latency is adjustable.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tri_raster_sched;
    import tri_pkg::*;

    localparam int BUDGET = 20000;
`ifdef TRI_RASTER_EARLY_EXIT_EN
    localparam int EXP_REQ_05 = 2;
`else
    localparam int EXP_REQ_05 = 3;
`endif

    logic             clk;
    logic             rst_n;
    logic             tri_valid;
    logic             tri_ready;
    logic [X_W-1:0]   tri_ax, tri_bx, tri_cx;
    logic [Y_W-1:0]   tri_ay, tri_by, tri_cy;
    logic             det_req;
    logic             det_ack;
    logic [X_W-1:0]   det_px, det_qx, det_rx;
    logic [Y_W-1:0]   det_py, det_qy, det_ry;
    logic             det_rsp_valid;
    logic [DET_W-1:0] det_rsp_abs;
    logic             pix_valid;
    logic             pix_ready;
    logic [X_W-1:0]   pix_x;
    logic [Y_W-1:0]   pix_y;
    logic             pix_inside;
    logic             pix_last;
    logic             tri_done;

    tri_raster_sched dut (
        .clk(clk), .rst_n(rst_n),
        .tri_valid(tri_valid), .tri_ready(tri_ready),
        .tri_ax(tri_ax), .tri_bx(tri_bx), .tri_cx(tri_cx),
        .tri_ay(tri_ay), .tri_by(tri_by), .tri_cy(tri_cy),
        .det_req(det_req), .det_ack(det_ack),
        .det_px(det_px), .det_qx(det_qx), .det_rx(det_rx),
        .det_py(det_py), .det_qy(det_qy), .det_ry(det_ry),
        .det_rsp_valid(det_rsp_valid), .det_rsp_abs(det_rsp_abs),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_inside(pix_inside), .pix_last(pix_last),
        .tri_done(tri_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Shared |det| unit model controls (written by main) and state (written by model)
    int ack_dly = 0;
    int rsp_dly = 0;
    int stray_req = 0;
    int stray_done = 0;
    int n_ack = 0;

    // Per-run observations
    logic inside_map [0:15][0:15];
    int   reqs_map   [0:15][0:15];
    int   pix_cnt, nvalid, last_cnt, last_x, last_y, done_cnt, done_cyc, area_seen, run_ack0;

    function automatic logic [DET_W-1:0] det_abs(input logic [X_W-1:0] px, qx, rx,
                                                 input logic [Y_W-1:0] py, qy, ry);
        longint s;
        logic [63:0] u;
        s = longint'(px) * longint'(qy) + longint'(rx) * longint'(py) + longint'(qx) * longint'(ry)
          - longint'(qx) * longint'(py) - longint'(px) * longint'(ry) - longint'(rx) * longint'(qy);
        if (s < 0) s = -s;
        u = s;
        return u[DET_W-1:0];
    endfunction

    // Behavioural shared determinant unit, driven on the falling edge
    initial begin : det_model
        int acnt;
        int rcnt;
        bit pend;
        bit seen;
        logic [DET_W-1:0] rval;
        acnt = 0; rcnt = 0; pend = 0; seen = 0; rval = '0;
        det_ack = 1'b0; det_rsp_valid = 1'b0; det_rsp_abs = '0;
        forever begin
            @(negedge clk);
            det_ack = 1'b0;
            det_rsp_valid = 1'b0;
            if (stray_req != stray_done) begin
                det_rsp_valid = 1'b1;
                det_rsp_abs   = 22'h3FFFF;
                stray_done++;
            end else if (pend) begin
                if (rcnt == 0) begin
                    det_rsp_valid = 1'b1;
                    det_rsp_abs   = rval;
                    pend = 0;
                end else begin
                    rcnt--;
                end
            end else if (det_req) begin
                if (!seen) begin
                    seen = 1;
                    acnt = ack_dly;
                end
                if (acnt == 0) begin
                    det_ack = 1'b1;
                    n_ack++;
                    rval = det_abs(det_px, det_qx, det_rx, det_py, det_qy, det_ry);
                    pend = 1;
                    rcnt = rsp_dly;
                    seen = 0;
                end else begin
                    acnt--;
                end
            end else begin
                seen = 0;
            end
        end
    end

    // Offer one triangle and observe until tri_done (or reset abort at rst_at pixels)
    task automatic run_tri(input logic [X_W-1:0] ax, bx, cx, input logic [Y_W-1:0] ay, by, cy,
                           input int xmin, xmax, ymin, input int sx, sy, sn, input int rst_at);
        int cyc, exp_x, exp_y, stall_left, ack_mark;
        bit fin, seen_done, trk, prev_req, stall_cap;
        logic [X_W-1:0] cpx, cqx, crx, s_x;
        logic [Y_W-1:0] cpy, cqy, cry, s_y;
        logic s_in;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                inside_map[i][j] = 1'b0;
                reqs_map[i][j]   = -1;
            end
        end
        pix_cnt = 0; nvalid = 0; last_cnt = 0; last_x = -1; last_y = -1;
        done_cnt = 0; done_cyc = -1; area_seen = -1;
        run_ack0 = n_ack; ack_mark = n_ack;
        exp_x = xmin; exp_y = ymin; stall_left = sn; cyc = 0;
        fin = 0; seen_done = 0; trk = 0; prev_req = 0; stall_cap = 0;
        cpx = '0; cqx = '0; crx = '0; cpy = '0; cqy = '0; cry = '0;
        s_x = '0; s_y = '0; s_in = 1'b0;
        @(negedge clk); #1;
        tri_ax = ax; tri_bx = bx; tri_cx = cx;
        tri_ay = ay; tri_by = by; tri_cy = cy;
        tri_valid = 1'b1;
        pix_ready = 1'b1;
        while (!fin) begin
            @(negedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                tri_valid = 1'b0;
                checks++;
                if (tri_ready !== 1'b0) begin
                    errors++; $display("FAIL accept_ready got %b exp 0", tri_ready);
                end
            end
            if (seen_done) begin
                checks++;
                if (tri_ready !== 1'b1) begin
                    errors++; $display("FAIL ready_after_done got %b exp 1", tri_ready);
                end
                fin = 1;
            end
            // Operands must hold from the first request cycle until ack
            if (det_req) begin
                if (trk) begin
                    checks++;
                    if ({det_px, det_qx, det_rx, det_py, det_qy, det_ry} !== {cpx, cqx, crx, cpy, cqy, cry}) begin
                        errors++;
                        $display("FAIL det_operand_hold got %0d,%0d,%0d/%0d,%0d,%0d exp %0d,%0d,%0d/%0d,%0d,%0d",
                                 det_px, det_qx, det_rx, det_py, det_qy, det_ry, cpx, cqx, crx, cpy, cqy, cry);
                    end
                end else begin
                    cpx = det_px; cqx = det_qx; crx = det_rx;
                    cpy = det_py; cqy = det_qy; cry = det_ry;
                    trk = 1;
                end
                if (det_ack) trk = 0;
            end else begin
                trk = 0;
            end
            if (det_rsp_valid && area_seen < 0) area_seen = int'(det_rsp_abs);
            if (pix_valid) nvalid++;
            if (pix_valid && int'(pix_x) == sx && int'(pix_y) == sy && stall_left > 0) begin
                pix_ready = 1'b0;
                checks++;
                if (det_req !== 1'b0) begin
                    errors++; $display("FAIL stall_det_req got %b exp 0", det_req);
                end
                if (stall_cap) begin
                    checks++;
                    if ({pix_x, pix_y, pix_inside} !== {s_x, s_y, s_in}) begin
                        errors++;
                        $display("FAIL stall_hold got (%0d,%0d,%b) exp (%0d,%0d,%b)",
                                 pix_x, pix_y, pix_inside, s_x, s_y, s_in);
                    end
                end else begin
                    s_x = pix_x; s_y = pix_y; s_in = pix_inside; stall_cap = 1;
                end
                stall_left--;
            end else begin
                pix_ready = 1'b1;
            end
            if (pix_valid && pix_ready) begin
                checks++;
                if (int'(pix_x) != exp_x || int'(pix_y) != exp_y) begin
                    errors++;
                    $display("FAIL pix_order got (%0d,%0d) exp (%0d,%0d)", pix_x, pix_y, exp_x, exp_y);
                end
                if (pix_x < 16 && pix_y < 16) begin
                    inside_map[pix_y][pix_x] = pix_inside;
                    reqs_map[pix_y][pix_x]   = n_ack - ack_mark;
                end
                ack_mark = n_ack;
                if (pix_last) begin
                    last_cnt++; last_x = int'(pix_x); last_y = int'(pix_y);
                end
                pix_cnt++;
                if (exp_x == xmax) begin
                    exp_x = xmin; exp_y++;
                end else begin
                    exp_x++;
                end
            end
            if (tri_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                seen_done = 1;
                checks++;
                if (tri_ready !== 1'b0) begin
                    errors++; $display("FAIL ready_at_done got %b exp 0", tri_ready);
                end
            end
            if (rst_at >= 0 && pix_cnt == rst_at && prev_req && !det_req) begin
                rst_n = 1'b0;
                @(negedge clk); #1;
                rst_n = 1'b1;
                fin = 1;
            end
            prev_req = det_req;
            if (cyc > BUDGET && !fin) begin
                checks++; errors++;
                $display("FAIL run_timeout got %0d cycles exp <= %0d", cyc, BUDGET);
                fin = 1;
            end
        end
        pix_ready = 1'b1;
    endtask

    // Results for A(0,0) B(5,5) C(10,0): inside iff y <= x and x + y <= 10
    task automatic check_tri1(input string tag);
        logic e;
        checks++;
        if (pix_cnt != 66) begin errors++; $display("FAIL %s pix_count got %0d exp 66", tag, pix_cnt); end
        checks++;
        if (area_seen != 50) begin errors++; $display("FAIL %s area got %0d exp 50", tag, area_seen); end
        checks++;
        if (last_cnt != 1 || last_x != 10 || last_y != 5) begin
            errors++; $display("FAIL %s pix_last got n=%0d (%0d,%0d) exp n=1 (10,5)", tag, last_cnt, last_x, last_y);
        end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL %s tri_done_count got %0d exp 1", tag, done_cnt); end
        for (int y = 0; y <= 5; y++) begin
            for (int x = 0; x <= 10; x++) begin
                e = (y <= x) && (x + y <= 10);
                checks++;
                if (inside_map[y][x] !== e) begin
                    errors++; $display("FAIL %s inside(%0d,%0d) got %b exp %b", tag, x, y, inside_map[y][x], e);
                end
            end
        end
        checks++;
        if (reqs_map[0][0] != 4) begin errors++; $display("FAIL %s reqs(0,0) got %0d exp 4", tag, reqs_map[0][0]); end
        checks++;
        if (reqs_map[5][0] != EXP_REQ_05) begin
            errors++; $display("FAIL %s reqs(0,5) got %0d exp %0d", tag, reqs_map[5][0], EXP_REQ_05);
        end
`ifndef TRI_RASTER_EARLY_EXIT_EN
        checks++;
        if (n_ack - run_ack0 != 199) begin
            errors++; $display("FAIL %s det_req_total got %0d exp 199", tag, n_ack - run_ack0);
        end
`endif
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if (tri_ready !== 1'b1 || det_req !== 1'b0 || pix_valid !== 1'b0 || tri_done !== 1'b0) begin
            errors++;
            $display("FAIL %s idle got ready=%b req=%b valid=%b done=%b exp 1 0 0 0",
                     tag, tri_ready, det_req, pix_valid, tri_done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tri_valid = 1'b0; pix_ready = 1'b1;
        tri_ax = '0; tri_bx = '0; tri_cx = '0; tri_ay = '0; tri_by = '0; tri_cy = '0;
        repeat (3) @(negedge clk);
        #1;
        check_idle("reset");
        checks++;
        if (pix_last !== 1'b0 || pix_x !== '0 || pix_y !== '0) begin
            errors++; $display("FAIL reset_pix got last=%b x=%0d y=%0d exp 0 0 0", pix_last, pix_x, pix_y);
        end
        checks++;
        if ({det_px, det_qx, det_rx, det_py, det_qy, det_ry} !== '0) begin
            errors++; $display("FAIL reset_operands got %0d,%0d,%0d/%0d,%0d,%0d exp all 0",
                               det_px, det_qx, det_rx, det_py, det_qy, det_ry);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        ack_dly = 0; rsp_dly = 0;
        run_tri(11'd0, 11'd5, 11'd10, 10'd0, 10'd5, 10'd0, 0, 10, 0, -1, -1, 0, -1);
        check_tri1("basic");
`ifndef TRI_RASTER_EARLY_EXIT_EN
        checks++;
        if (done_cyc != 532) begin errors++; $display("FAIL basic done_cycle got %0d exp 532", done_cyc); end
`endif
    endtask

    task automatic test_degenerate();
        ack_dly = 0; rsp_dly = 0;
        run_tri(11'd0, 11'd5, 11'd10, 10'd0, 10'd5, 10'd10, 0, 10, 0, -1, -1, 0, -1);
        checks++;
        if (n_ack - run_ack0 != 1) begin errors++; $display("FAIL degen_reqs got %0d exp 1", n_ack - run_ack0); end
        checks++;
        if (nvalid != 0) begin errors++; $display("FAIL degen_pix_valid got %0d exp 0", nvalid); end
        checks++;
        if (done_cnt != 1 || done_cyc != 4) begin
            errors++; $display("FAIL degen_done got n=%0d cyc=%0d exp n=1 cyc=4", done_cnt, done_cyc);
        end
        checks++;
        if (area_seen != 0) begin errors++; $display("FAIL degen_area got %0d exp 0", area_seen); end
    endtask

    task automatic test_backpressure();
        ack_dly = 0; rsp_dly = 0;
        run_tri(11'd0, 11'd5, 11'd10, 10'd0, 10'd5, 10'd0, 0, 10, 0, 3, 1, 5, -1);
        check_tri1("backpressure");
        checks++;
        if (inside_map[1][3] !== 1'b1) begin
            errors++; $display("FAIL stall_pixel_inside got %b exp 1", inside_map[1][3]);
        end
    endtask

    task automatic test_delayed();
        ack_dly = 4; rsp_dly = 7;
        run_tri(11'd0, 11'd5, 11'd10, 10'd0, 10'd5, 10'd0, 0, 10, 0, -1, -1, 0, -1);
        check_tri1("delayed");
        ack_dly = 0; rsp_dly = 0;
        stray_req++;
        repeat (4) begin
            @(negedge clk); #1;
            check_idle("stray_rsp");
        end
    endtask

    task automatic test_reset_mid();
        ack_dly = 0; rsp_dly = 3;
        run_tri(11'd0, 11'd5, 11'd10, 10'd0, 10'd5, 10'd0, 0, 10, 0, -1, -1, 0, 2);
        check_idle("mid_reset");
        checks++;
        if (pix_cnt != 2) begin errors++; $display("FAIL mid_reset_pixels got %0d exp 2", pix_cnt); end
        // The dropped response lands while idle and must be ignored
        repeat (8) begin
            @(negedge clk); #1;
            check_idle("mid_reset_drain");
        end
        rsp_dly = 0;
        run_tri(11'd0, 11'd5, 11'd10, 10'd0, 10'd5, 10'd0, 0, 10, 0, -1, -1, 0, -1);
        check_tri1("after_reset");
    endtask

    initial begin
        rst_n = 1'b0;
        tri_valid = 1'b0;
        pix_ready = 1'b1;
        tri_ax = '0; tri_bx = '0; tri_cx = '0; tri_ay = '0; tri_by = '0; tri_cy = '0;
        test_reset();
        test_basic();
        test_degenerate();
        test_backpressure();
        test_delayed();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
